// File: rtl/div32_seq_pkg.sv
// Shared constants and state encoding for the sequential signed divider.
package div32_seq_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div32_seq_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and keep or restore.
module div32_seq_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH:0]   divisor,
  output logic [WIDTH-1:0] rem_c,
  output logic [WIDTH-1:0] quo_c
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The partial remainder is always below the divisor, so the shifted value
  // minus the divisor fits WIDTH+1 signed bits; its sign picks restore/keep.
  assign shifted = {rem_in, quo_in[WIDTH-1]};
  assign diff    = shifted - divisor;

  assign rem_c = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_c = {quo_in[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/div32_seq.sv
// Multi-cycle signed divider: magnitude restoring division, one bit per cycle,
// followed by a sign-fix cycle. Quotient truncates toward zero.
module div32_seq
  import div32_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   mag_b;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  // |-2^(W-1)| reads correctly as an unsigned W-bit magnitude.
  assign abs_a = data_operandA[WIDTH-1] ? ('0 - data_operandA) : data_operandA;
  assign abs_b = data_operandB[WIDTH-1] ? ('0 - data_operandB) : data_operandB;

  div32_seq_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .divisor (mag_b),
    .rem_c   (step_rem),
    .quo_c   (step_quo)
  );

  // A start strobe wins over any op in flight, aborting it without RDY.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= DIV_IDLE;
      cnt            <= '0;
      rem            <= '0;
      quo            <= '0;
      mag_b          <= '0;
      sign_q         <= 1'b0;
      sign_r         <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_DIV) begin
        cnt <= '0;
        if (data_operandB == '0) begin
          state          <= DIV_IDLE;
          busy           <= 1'b0;
          data_result    <= '0;
          data_remainder <= data_operandA;
          data_exception <= 1'b1;
          data_resultRDY <= 1'b1;
        end else begin
          state  <= DIV_RUN;
          busy   <= 1'b1;
          rem    <= '0;
          quo    <= abs_a;
          mag_b  <= {1'b0, abs_b};
          sign_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          sign_r <= data_operandA[WIDTH-1];
        end
      end else begin
        case (state)
          DIV_RUN: begin
            rem <= step_rem;
            quo <= step_quo;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) state <= DIV_FIX;
          end
          DIV_FIX: begin
            data_result    <= sign_q ? ('0 - quo) : quo;
            data_remainder <= sign_r ? ('0 - rem) : rem;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
            state          <= DIV_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// Directed bench for div32_seq: signed cases, divide by zero, overflow,
// restart while busy and reset mid-operation.
module tb_div32_seq;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  div32_seq dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive a start strobe so it is sampled on the next rising edge (E0).
  task automatic pulse(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_DIV      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1 ctrl_DIV = 1'b0;
  endtask

  // From just after E0: lat = index of the edge after which RDY shows; -1 on timeout.
  task automatic wait_done(output int lat, output int busyc);
    lat   = -1;
    busyc = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (busy) busyc++;
      if (data_resultRDY) begin
        lat = k;
        break;
      end
      @(posedge clock);
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic ee,
                       input int elat, input int ebusy);
    int lat;
    int busyc;
    pulse(a, b);
    wait_done(lat, busyc);
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " busy cycles"}, 32'(busyc), 32'(ebusy));
    check({tag, " result"}, data_result, eq);
    check({tag, " remainder"}, data_remainder, er);
    check({tag, " exception"}, 32'(data_exception), 32'(ee));
    check({tag, " busy at rdy"}, 32'(busy), 32'd0);
    @(posedge clock);
    @(negedge clock);
    check({tag, " rdy one cycle"}, 32'(data_resultRDY), 32'd0);
    check({tag, " result held"}, data_result, eq);
  endtask

  initial begin
    int lat;
    int busyc;
    int rdy_seen;

    reset_n       = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("reset result", data_result, 32'd0);
    check("reset remainder", data_remainder, 32'd0);
    check("reset exception", 32'(data_exception), 32'd0);
    check("reset rdy", 32'(data_resultRDY), 32'd0);
    check("reset busy", 32'(busy), 32'd0);

    do_op("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 33);
    do_op("-100/7", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33, 33);
    do_op("100/-7", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 33, 33);
    do_op("-7/-2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 33, 33);
    do_op("5/0", 32'd5, 32'd0, 32'd0, 32'd5, 1'b1, 0, 0);

    // Outputs from the divide-by-zero must persist while the next op runs.
    pulse(32'd100, 32'd7);
    @(negedge clock);
    check("hold busy", 32'(busy), 32'd1);
    check("hold exception", 32'(data_exception), 32'd1);
    check("hold remainder", data_remainder, 32'd5);
    wait_done(lat, busyc);
    check("hold op result", data_result, 32'd14);

    do_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33, 33);
    do_op("maxpos/1", 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0, 33, 33);

    // Restart at E10: the first op must never signal RDY.
    pulse(32'd100, 32'd7);
    rdy_seen = 0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    check("restart no early rdy", 32'(rdy_seen), 32'd0);
    pulse(32'd9, 32'd3);
    wait_done(lat, busyc);
    check("restart latency", 32'(lat), 32'd33);
    check("restart result", data_result, 32'd3);
    check("restart remainder", data_remainder, 32'd0);
    @(posedge clock);
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
      @(posedge clock);
    end
    check("restart single rdy", 32'(rdy_seen), 32'd0);

    // Reset at E15 aborts the op.
    pulse(32'd100, 32'd7);
    repeat (14) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("abort result", data_result, 32'd0);
    check("abort remainder", data_remainder, 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    check("abort no rdy", 32'(rdy_seen), 32'd0);
    do_op("20/4", 32'd20, 32'd4, 32'd5, 32'd0, 1'b0, 33, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
